// File: rtl/data_mem_bridge_pkg.sv
// Shared encodings and lane helpers for the word-to-byte data memory bridge.
package data_mem_bridge_pkg;

  localparam logic RST_ACTIVE = 1'b1;
  localparam logic EN_ACTIVE  = 1'b1;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] lane;
  } lane_pick_t;

  // Lane k occupies bits [31-8k : 24-8k] (big-endian).
  function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                  input logic [1:0] lane);
    return word[WORD_W-1-BYTE_W*int'(lane) -: BYTE_W];
  endfunction

  function automatic logic [WORD_W-1:0] lane_set(input logic [WORD_W-1:0] word,
                                                 input logic [1:0] lane,
                                                 input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] w;
    w = word;
    w[WORD_W-1-BYTE_W*int'(lane) -: BYTE_W] = b;
    return w;
  endfunction

  // Lowest enabled lane >= start; select bit 3 is lane 0.
  function automatic lane_pick_t pick_lane(input logic [3:0] sel, input logic [2:0] start);
    lane_pick_t p;
    p = '0;
    for (int k = 3; k >= 0; k--) begin
      if ((k >= int'(start)) && sel[3-k]) begin
        p.found = 1'b1;
        p.lane  = 2'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/data_mem_bridge_if.sv
// Memory-stage data port: word requests in, assembled read word and stall out.
interface data_mem_bridge_if;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [3:0]  mem_write_select;
  logic [31:0] mem_write_data;
  logic        stall_request;

  modport master (
    output mem_read_enable, mem_read_address,
    output mem_write_enable, mem_write_address, mem_write_select, mem_write_data,
    input  mem_read_data, stall_request
  );

  modport slave (
    input  mem_read_enable, mem_read_address,
    input  mem_write_enable, mem_write_address, mem_write_select, mem_write_data,
    output mem_read_data, stall_request
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Serves word reads/writes from the memory stage over an 8-bit external memory,
// one byte lane per cycle, stalling the pipeline until the access completes.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned EXT_ADDR_WIDTH = 17,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  data_mem_bridge_if.slave          mem,
  output logic [EXT_ADDR_WIDTH-1:0] ext_address,
  output logic                      ext_read_enable,
  output logic                      ext_write_enable,
  output logic [BYTE_W-1:0]         ext_write_data,
  input  logic [BYTE_W-1:0]         ext_read_data
);

  localparam int unsigned WA_W    = EXT_ADDR_WIDTH - 2;
  localparam logic [2:0]  RD_LAT  = 3'(READ_LATENCY);
  localparam logic [2:0]  RD_LAST = 3'(READ_LATENCY + 3);

  state_e                    r_state, w_state_nxt;
  logic [WA_W-1:0]           r_wr_addr, r_rd_addr;
  logic [WORD_W-1:0]         r_wr_data;
  logic [3:0]                r_sel;
  logic                      r_rd_pend;
  logic [1:0]                r_lane, w_lane_nxt;
  logic [2:0]                r_rcyc, w_rcyc_nxt;
  logic [WORD_W-1:0]         r_rd_buf, w_rd_buf_nxt;
  logic [WORD_W-1:0]         r_rd_data, w_rd_data_nxt;
  logic [EXT_ADDR_WIDTH-1:0] r_ext_addr, w_ext_addr_nxt;
  logic                      r_ext_re, w_ext_re_nxt;
  logic                      r_ext_we, w_ext_we_nxt;
  logic [BYTE_W-1:0]         r_ext_wd, w_ext_wd_nxt;

  logic            w_wr_req, w_rd_req, w_rd_last;
  lane_pick_t      w_first, w_next;
  logic [WA_W-1:0] w_req_wr_addr, w_req_rd_addr;
  logic            w_unused;

  assign w_wr_req      = (mem.mem_write_enable == EN_ACTIVE) && (mem.mem_write_select != 4'd0);
  assign w_rd_req      = (mem.mem_read_enable == EN_ACTIVE);
  assign w_req_wr_addr = mem.mem_write_address[EXT_ADDR_WIDTH-1:2];
  assign w_req_rd_addr = mem.mem_read_address[EXT_ADDR_WIDTH-1:2];
  assign w_first       = pick_lane(mem.mem_write_select, 3'd0);
  assign w_next        = pick_lane(r_sel, 3'(r_lane) + 3'd1);
  assign w_rd_last     = (r_rcyc == RD_LAST);
  assign w_unused      = ^{mem.mem_read_address[31:EXT_ADDR_WIDTH], mem.mem_read_address[1:0],
                           mem.mem_write_address[31:EXT_ADDR_WIDTH], mem.mem_write_address[1:0]};

  // State register
  always_ff @(posedge clock) begin
    if (reset == RST_ACTIVE) r_state <= ST_IDLE;
    else                     r_state <= w_state_nxt;
  end

  // Next-state logic; a write with a pending read continues straight into READ
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_req)      w_state_nxt = ST_WRITE;
        else if (w_rd_req) w_state_nxt = ST_READ;
      end
      ST_WRITE: if (!w_next.found) w_state_nxt = r_rd_pend ? ST_READ : ST_DONE;
      ST_READ:  if (w_rd_last)     w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered lane strobes, address, data and read assembly
  always_comb begin
    w_lane_nxt     = r_lane;
    w_rcyc_nxt     = r_rcyc;
    w_rd_buf_nxt   = r_rd_buf;
    w_rd_data_nxt  = r_rd_data;
    w_ext_addr_nxt = '0;
    w_ext_re_nxt   = 1'b0;
    w_ext_we_nxt   = 1'b0;
    w_ext_wd_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_req) begin
          w_lane_nxt     = w_first.lane;
          w_ext_we_nxt   = 1'b1;
          w_ext_addr_nxt = {w_req_wr_addr, w_first.lane};
          w_ext_wd_nxt   = lane_byte(mem.mem_write_data, w_first.lane);
        end else if (w_rd_req) begin
          w_rcyc_nxt     = 3'd0;
          w_ext_re_nxt   = 1'b1;
          w_ext_addr_nxt = {w_req_rd_addr, 2'd0};
        end
      end
      ST_WRITE: begin
        if (w_next.found) begin
          w_lane_nxt     = w_next.lane;
          w_ext_we_nxt   = 1'b1;
          w_ext_addr_nxt = {r_wr_addr, w_next.lane};
          w_ext_wd_nxt   = lane_byte(r_wr_data, w_next.lane);
        end else if (r_rd_pend) begin
          w_rcyc_nxt     = 3'd0;
          w_ext_re_nxt   = 1'b1;
          w_ext_addr_nxt = {r_rd_addr, 2'd0};
        end
      end
      ST_READ: begin
        // Issue runs on cycles 0..3, capture trails it by READ_LATENCY cycles
        w_rcyc_nxt = r_rcyc + 3'd1;
        if (r_rcyc < 3'd3) begin
          w_ext_re_nxt   = 1'b1;
          w_ext_addr_nxt = {r_rd_addr, 2'(r_rcyc + 3'd1)};
        end
        if (r_rcyc >= RD_LAT) begin
          w_rd_buf_nxt = lane_set(r_rd_buf, 2'(r_rcyc - RD_LAT), ext_read_data);
          if (w_rd_last) w_rd_data_nxt = w_rd_buf_nxt;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; request fields are captured only from IDLE
  always_ff @(posedge clock) begin
    if (reset == RST_ACTIVE) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_wr_data  <= '0;
      r_sel      <= '0;
      r_rd_pend  <= 1'b0;
      r_lane     <= '0;
      r_rcyc     <= '0;
      r_rd_buf   <= '0;
      r_rd_data  <= '0;
      r_ext_addr <= '0;
      r_ext_re   <= 1'b0;
      r_ext_we   <= 1'b0;
      r_ext_wd   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (w_wr_req || w_rd_req)) begin
        r_wr_addr <= w_req_wr_addr;
        r_rd_addr <= w_req_rd_addr;
        r_wr_data <= mem.mem_write_data;
        r_sel     <= mem.mem_write_select;
        r_rd_pend <= w_rd_req;
      end
      r_lane     <= w_lane_nxt;
      r_rcyc     <= w_rcyc_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_ext_addr <= w_ext_addr_nxt;
      r_ext_re   <= w_ext_re_nxt;
      r_ext_we   <= w_ext_we_nxt;
      r_ext_wd   <= w_ext_wd_nxt;
    end
  end

  assign ext_address       = r_ext_addr;
  assign ext_read_enable   = r_ext_re;
  assign ext_write_enable  = r_ext_we;
  assign ext_write_data    = r_ext_wd;
  assign mem.mem_read_data = r_rd_data;
  assign mem.stall_request = ((r_state == ST_IDLE) && (w_rd_req || w_wr_req)) ||
                             (r_state == ST_WRITE) || (r_state == ST_READ);

endmodule

// File: tb/tb_data_mem_bridge.sv
// Scoreboard bench for data_mem_bridge: two instances (read latency 1 and 3) share one byte memory.
module tb_data_mem_bridge;
  import data_mem_bridge_pkg::*;

  localparam int unsigned AW = 17;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_ev_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  data_mem_bridge_if bus1();
  data_mem_bridge_if bus3();

  logic [AW-1:0] a1, a3;
  logic          re1, re3, we1, we3;
  logic [7:0]    wd1, wd3, rd1, rd3;

  data_mem_bridge #(.EXT_ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .mem(bus1),
    .ext_address(a1), .ext_read_enable(re1), .ext_write_enable(we1),
    .ext_write_data(wd1), .ext_read_data(rd1)
  );

  data_mem_bridge #(.EXT_ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .mem(bus3),
    .ext_address(a3), .ext_read_enable(re3), .ext_write_enable(we3),
    .ext_write_data(wd3), .ext_read_data(rd3)
  );

  // Stimulus goes to one instance at a time; the other sees idle inputs
  int          dut_sel;
  logic        t_rd_en, t_wr_en;
  logic [31:0] t_rd_addr, t_wr_addr, t_wd;
  logic [3:0]  t_sel;

  assign bus1.mem_read_enable   = (dut_sel == 0) && t_rd_en;
  assign bus1.mem_read_address  = t_rd_addr;
  assign bus1.mem_write_enable  = (dut_sel == 0) && t_wr_en;
  assign bus1.mem_write_address = t_wr_addr;
  assign bus1.mem_write_select  = t_sel;
  assign bus1.mem_write_data    = t_wd;
  assign bus3.mem_read_enable   = (dut_sel == 1) && t_rd_en;
  assign bus3.mem_read_address  = t_rd_addr;
  assign bus3.mem_write_enable  = (dut_sel == 1) && t_wr_en;
  assign bus3.mem_write_address = t_wr_addr;
  assign bus3.mem_write_select  = t_sel;
  assign bus3.mem_write_data    = t_wd;

  logic          m_stall, m_re, m_we;
  logic [31:0]   m_rdata;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wd;
  assign m_stall = (dut_sel == 0) ? bus1.stall_request : bus3.stall_request;
  assign m_rdata = (dut_sel == 0) ? bus1.mem_read_data : bus3.mem_read_data;
  assign m_re    = (dut_sel == 0) ? re1 : re3;
  assign m_we    = (dut_sel == 0) ? we1 : we3;
  assign m_addr  = (dut_sel == 0) ? a1 : a3;
  assign m_wd    = (dut_sel == 0) ? wd1 : wd3;

  // External byte memory with per-instance read pipelines
  logic       mem_init;
  logic [7:0] ext_mem [0:4095];
  logic [7:0] exp_mem [0:4095];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [0:2];

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      32'h104: return 8'h11;
      32'h105: return 8'h22;
      32'h106: return 8'h33;
      32'h107: return 8'h44;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  always @(posedge clock) begin
    pipe1    <= ext_mem[a1[11:0]];
    pipe3[0] <= ext_mem[a3[11:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) ext_mem[i] <= init_byte(i);
    end else if (m_we) begin
      ext_mem[m_addr[11:0]] <= m_wd;
    end
  end
  assign rd1 = pipe1;
  assign rd3 = pipe3[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  wr_ev_t        exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];
  logic [31:0]   exp_rdata [2];
  logic          mon_en;
  wr_ev_t        mon_ev;
  logic [AW-1:0] mon_ra;

  // Observe external strobes against the expected lane sequence
  always @(negedge clock) begin
    if (mon_en) begin
      check_eq("strobe_overlap", 64'(m_we & m_re), 64'd0);
      if (m_we) begin
        check_eq("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
        if (exp_wr_q.size() != 0) begin
          mon_ev = exp_wr_q.pop_front();
          check_eq("wr_addr", 64'(m_addr), 64'(mon_ev.addr));
          check_eq("wr_data", 64'(m_wd), 64'(mon_ev.data));
        end
      end
      if (m_re) begin
        check_eq("rd_expected", 64'(exp_rd_q.size() != 0), 64'd1);
        if (exp_rd_q.size() != 0) begin
          mon_ra = exp_rd_q.pop_front();
          check_eq("rd_addr", 64'(m_addr), 64'(mon_ra));
        end
      end
    end
  end

  task automatic do_req(input string tag, input logic rd, input logic [31:0] ra,
                        input logic wr, input logic [31:0] wa, input logic [3:0] sel,
                        input logic [31:0] wd);
    int            lat;
    int            exp_stall;
    int            n;
    logic          wr_req;
    logic [AW-1:0] a;
    logic [31:0]   w;
    lat       = (dut_sel == 0) ? 1 : 3;
    wr_req    = wr && (sel != 4'd0);
    exp_stall = 0;
    if (wr_req) begin
      exp_stall = 1;
      for (int k = 0; k < 4; k++) begin
        if (sel[3-k]) begin
          a = {wa[AW-1:2], 2'(k)};
          exp_wr_q.push_back({a, wd[31-8*k -: 8]});
          exp_mem[a[11:0]] = wd[31-8*k -: 8];
          exp_stall++;
        end
      end
    end
    if (rd) begin
      if (!wr_req) exp_stall = 1;
      w = '0;
      for (int k = 0; k < 4; k++) begin
        a = {ra[AW-1:2], 2'(k)};
        exp_rd_q.push_back(a);
        w[31-8*k -: 8] = exp_mem[a[11:0]];
      end
      exp_stall += 4 + lat;
      exp_rdata[dut_sel] = w;
    end
    t_rd_en = rd; t_rd_addr = ra; t_wr_en = wr; t_wr_addr = wa; t_sel = sel; t_wd = wd;
    #1;
    n = 0;
    while ((m_stall === 1'b1) && (n < 64)) begin
      n++;
      @(posedge clock); #1;
    end
    check_eq({tag, "_stall"}, 64'(n), 64'(exp_stall));
    check_eq({tag, "_rdata"}, 64'(m_rdata), 64'(exp_rdata[dut_sel]));
    t_rd_en = 1'b0; t_wr_en = 1'b0;
    @(posedge clock); #1;
    check_eq({tag, "_idle"}, 64'(m_stall), 64'd0);
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1; mon_en = 1'b0; dut_sel = 0;
    t_rd_en = 1'b0; t_wr_en = 1'b0; t_rd_addr = '0; t_wr_addr = '0; t_sel = '0; t_wd = '0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_byte(i);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0; mem_init = 1'b0; mon_en = 1'b1;

    check_eq("rst_addr",   64'(a1), 64'd0);
    check_eq("rst_re",     64'(re1), 64'd0);
    check_eq("rst_we",     64'(we1), 64'd0);
    check_eq("rst_wd",     64'(wd1), 64'd0);
    check_eq("rst_rdata1", 64'(bus1.mem_read_data), 64'd0);
    check_eq("rst_rdata3", 64'(bus3.mem_read_data), 64'd0);
    check_eq("rst_stall",  64'(m_stall), 64'd0);

    do_req("rd_l1", 1'b1, 32'h0000_0107, 1'b0, '0, 4'b0000, '0);
    check_eq("rd_l1_word", 64'(bus1.mem_read_data), 64'h1122_3344);

    dut_sel = 1;
    do_req("rd_l3", 1'b1, 32'h0000_0107, 1'b0, '0, 4'b0000, '0);
    check_eq("rd_l3_word", 64'(bus3.mem_read_data), 64'h1122_3344);

    dut_sel = 0;
    do_req("wr_word", 1'b0, '0, 1'b1, 32'h0000_0104, 4'b1111, 32'hA1B2_C3D4);
    do_req("wr_byte", 1'b0, '0, 1'b1, 32'h0000_0206, 4'b0010, 32'h5A5A_5A5A);
    do_req("noop",    1'b0, '0, 1'b1, 32'h0000_0400, 4'b0000, 32'hDEAD_BEEF);
    repeat (2) @(posedge clock);
    #1;
    do_req("simul",   1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300, 4'b1000, 32'hEE00_0000);
    check_eq("simul_lane0", 64'(bus1.mem_read_data[31:24]), 64'hEE);
    do_req("rd_back", 1'b1, 32'h0000_0104, 1'b0, '0, 4'b0000, '0);
    check_eq("rd_back_word", 64'(bus1.mem_read_data), 64'hA1B2_C3D4);

    // Reset during the second READ cycle: lanes 0 and 1 have already been issued
    t_rd_en = 1'b1; t_rd_addr = 32'h0000_0200;
    exp_rd_q.push_back(17'h200);
    exp_rd_q.push_back(17'h201);
    @(posedge clock); #1;
    check_eq("mid_stall", 64'(m_stall), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1; t_rd_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    check_eq("mid_rst_addr",  64'(a1), 64'd0);
    check_eq("mid_rst_re",    64'(re1), 64'd0);
    check_eq("mid_rst_we",    64'(we1), 64'd0);
    check_eq("mid_rst_rdata", 64'(bus1.mem_read_data), 64'd0);
    check_eq("mid_rst_stall", 64'(m_stall), 64'd0);
    do_req("post_rst", 1'b1, 32'h0000_0204, 1'b0, '0, 4'b0000, '0);

    for (int i = 0; i < 8; i++) begin
      dut_sel = i % 2;
      do_req("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
             4'($urandom), $urandom);
    end

    check_eq("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    check_eq("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Responder side of the CPU data-memory port. Accepts word-wide read and write requests from the pipeline's memory stage.
- Serves each request over an 8-bit external byte memory (SRAM/flash-style), one byte lane per cycle.
- Holds `stall_request` high to freeze the pipeline until the access completes.
- Sits between the memory stage and the board-level byte memory. Replaces a word-wide single-cycle RAM.

Parameters:
- EXT_ADDR_WIDTH, 17, width of the external byte address. Upper request-address bits are ignored.
- READ_LATENCY, 1, cycles from an `ext_read_enable` cycle to the cycle in which `ext_read_data` is valid. Legal range 1..4.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset
- mem_read_enable  in  1  read request
- mem_read_address  in  32  read byte address. Bits [1:0] are ignored; the whole word is fetched.
- mem_read_data  out  32  assembled word, big-endian: lane 0 = bits [31:24]
- mem_write_enable  in  1  write request, qualified by a nonzero `mem_write_select`
- mem_write_address  in  32  write byte address. Bits [1:0] are ignored.
- mem_write_select  in  4  lane mask. Bit 3 = lane 0 = bits [31:24]; bit 0 = lane 3 = bits [7:0].
- mem_write_data  in  32  write word
- stall_request  out  1  pipeline freeze
- ext_address  out  EXT_ADDR_WIDTH  external byte address
- ext_read_enable  out  1  external byte read strobe
- ext_write_enable  out  1  external byte write strobe
- ext_write_data  out  8  external byte write data
- ext_read_data  in  8  external byte read data

Behaviour:
- Reset: `reset` is synchronous and active-high.
  - Reset values: all registered outputs 0; `mem_read_data` = 0; state IDLE.
  - Reset mid-operation aborts at that edge. External bytes already written stay written.
- Request qualification:
  - `wr_req` = `mem_write_enable` && (`mem_write_select` != 0).
  - `rd_req` = `mem_read_enable`.
  - `mem_write_enable` with select 0000 is a no-op: no stall, no external activity.
- States: IDLE, WRITE, READ, DONE.
- Inputs are sampled only in IDLE. The memory stage holds them stable while stalled.
- Stall rule:
  - `stall_request` = (IDLE && (`rd_req` || `wr_req`)) || WRITE || READ.
  - The IDLE term is combinational from the inputs; all other outputs are registered.
  - `stall_request` is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- IDLE transitions:
  - If `wr_req`: latch word address, data and select, plus the `rd_req` flag; go to WRITE.
  - Else if `rd_req`: latch the word address; go to READ.
  - A write has priority when both requests are present; the read follows in the same stall window.
- WRITE:
  - Lanes are walked k = 0..3, skipping lanes whose select bit is 0. One enabled lane is driven per cycle.
  - Per lane: `ext_write_enable` = 1, `ext_address` = {word_addr[EXT_ADDR_WIDTH-1:2], k}, `ext_write_data` = data[31-8k -: 8].
  - After the last enabled lane: go to READ if a read was latched, else DONE.
  - Duration equals the number of set select bits (1..4 cycles).
- READ (pipelined):
  - Issue lanes 0..3 on 4 consecutive cycles with `ext_read_enable` = 1 and the lane address.
  - Capture the byte for lane k at the end of the cycle READ_LATENCY after its issue, into bits [31-8k -: 8].
  - After the lane-3 capture, go to DONE.
  - READ lasts 4 + READ_LATENCY cycles.
  - `mem_read_data` updates only at the transition into DONE, never with partial words. It holds until the next read completes.
- DONE: one cycle, inputs ignored, then IDLE. A new request is accepted from IDLE on the following cycle.
- External strobes are never both high in the same cycle, and are 0 outside WRITE/READ.
- Read-data contract: the memory stage performs its own lane extraction (LB sign-extension) from the full word. The bridge never shifts data.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE 2'd0, WRITE 2'd1, READ 2'd2, DONE 2'd3;
  - the lane-to-bit-range convention (lane k ↔ bits [31-8k : 24-8k]);
  - the global reset/enable level defines.
- No sub-module. The lane issue/capture counters and the lane-skip priority logic stay inline.

Test Plan:
- Write word: 0x00000104, select 1111, data 0xA1B2C3D4 → 4 cycles of `ext_write_enable` to addresses 0x104..0x107 with data A1,B2,C3,D4; `stall_request` high 5 cycles (IDLE + 4), then low in DONE.
- Write byte at 0x00000206, select 0010, data 0x5A5A5A5A → exactly 1 external write, `ext_address` 0x206 (lane 2 = 0x204 + 2), data 0x5A; `stall_request` high 2 cycles.
- Read word with READ_LATENCY=1: `mem_read_address` 0x00000107, memory 0x104..0x107 = 11,22,33,44 → external reads at 0x104..0x107; `mem_read_data` = 0x11223344 in DONE; `stall_request` high 6 cycles (IDLE + 5). Repeat with READ_LATENCY=3 → 8 cycles.
- No-op: `mem_write_enable`=1, select 0000, `mem_read_enable`=0 → `stall_request` 0, no strobes, `mem_read_data` unchanged.
- Simultaneous: write 0x300 select 1000 data 0xEE000000 plus read 0x300 → one write (0x300 = EE) precedes four reads; `mem_read_data`[31:24] = 0xEE.
- Reset asserted on the 2nd READ cycle → next cycle all outputs 0, state IDLE; a fresh read afterwards completes normally.
